// File: rtl/product_accumulator.sv
// Block multiply-accumulate back end: sums BLOCK_LEN products per result with
// valid/ready handshakes on both sides. Define PRODUCT_ACC_SATURATE_EN to clamp on overflow instead of wrapping.
//
// state | meaning
// ACCUM | accepting products into the running block sum
// DONE  | block sum presented on acc_out, waiting for acc_ready
module product_accumulator #(
  parameter int PROD_W    = 8,
  parameter int ACC_W     = 10,
  parameter int BLOCK_LEN = 4,
  parameter int CNT_W     = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [PROD_W-1:0] prod_in,
  input  logic              prod_valid,
  output logic              prod_ready,
  input  logic              clear,
  output logic [ACC_W-1:0]  acc_out,
  output logic              acc_valid,
  input  logic              acc_ready,
  output logic [CNT_W-1:0]  count,
  output logic              overflow
);

  typedef enum logic {ACCUM, DONE} state_t;

  state_t           state_q, state_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [ACC_W-1:0] out_q, out_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ovf_q, ovf_d;
  logic [ACC_W:0]   sum_ext;
  logic             carry;

  assign sum_ext = {1'b0, acc_q} + (ACC_W+1)'(prod_in);
  assign carry   = sum_ext[ACC_W];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ACCUM;
      acc_q   <= '0;
      out_q   <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      out_q   <= out_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    acc_d      = acc_q;
    out_d      = out_q;
    cnt_d      = cnt_q;
    ovf_d      = ovf_q;
    prod_ready = (state_q == ACCUM) && !clear;

    if (clear) begin
      state_d = ACCUM;
      acc_d   = '0;
      cnt_d   = '0;
      ovf_d   = 1'b0;
    end else begin
      case (state_q)
        ACCUM: begin
          if (prod_valid) begin
            cnt_d = cnt_q + CNT_W'(1);
            if (carry) ovf_d = 1'b1;
`ifdef PRODUCT_ACC_SATURATE_EN
            // once clamped, the sum stays pinned for the rest of the block
            acc_d = (carry || ovf_q) ? '1 : sum_ext[ACC_W-1:0];
`else
            acc_d = sum_ext[ACC_W-1:0];
`endif
            if (cnt_q == CNT_W'(BLOCK_LEN - 1)) begin
              state_d = DONE;
              out_d   = acc_d;
            end
          end
        end
        DONE: begin
          if (acc_ready) begin
            state_d = ACCUM;
            acc_d   = '0;
            cnt_d   = '0;
            ovf_d   = 1'b0;
          end
        end
        default: state_d = ACCUM;
      endcase
    end
  end

  assign acc_out   = out_q;
  assign acc_valid = (state_q == DONE);
  assign count     = cnt_q;
  assign overflow  = ovf_q;

endmodule

// File: tb/tb_product_accumulator.sv
// Bench for product_accumulator: three instances (BLOCK_LEN 4, 8, 1) share one
// input stream and are checked every cycle against a true-sum block model.
module tb_product_accumulator;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] prod_in;
  logic       prod_valid;
  logic       acc_ready;
  logic       clear;

  logic [2:0] rdy, vld, ovf;
  logic [9:0] out [3];
  logic [3:0] cnt [3];

  int n_cmp = 0;
  int n_bad = 0;

  int bl    [3];
  int m_sum [3];
  int m_cnt [3];
  int m_out [3];

  always #5 clk = ~clk;

  product_accumulator #(.PROD_W(8), .ACC_W(10), .BLOCK_LEN(4), .CNT_W(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .prod_in(prod_in), .prod_valid(prod_valid),
    .prod_ready(rdy[0]), .clear(clear), .acc_out(out[0]), .acc_valid(vld[0]),
    .acc_ready(acc_ready), .count(cnt[0]), .overflow(ovf[0]));

  product_accumulator #(.PROD_W(8), .ACC_W(10), .BLOCK_LEN(8), .CNT_W(4)) dut8 (
    .clk(clk), .rst_n(rst_n), .prod_in(prod_in), .prod_valid(prod_valid),
    .prod_ready(rdy[1]), .clear(clear), .acc_out(out[1]), .acc_valid(vld[1]),
    .acc_ready(acc_ready), .count(cnt[1]), .overflow(ovf[1]));

  product_accumulator #(.PROD_W(8), .ACC_W(10), .BLOCK_LEN(1), .CNT_W(4)) dut1 (
    .clk(clk), .rst_n(rst_n), .prod_in(prod_in), .prod_valid(prod_valid),
    .prod_ready(rdy[2]), .clear(clear), .acc_out(out[2]), .acc_valid(vld[2]),
    .acc_ready(acc_ready), .count(cnt[2]), .overflow(ovf[2]));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Block result as a 10-bit register would present the true arithmetic sum.
  function automatic int result_of(input int sum);
`ifdef PRODUCT_ACC_SATURATE_EN
    return (sum > 1023) ? 1023 : sum;
`else
    return sum % 1024;
`endif
  endfunction

  task automatic check_regs();
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("acc_valid[%0d]", i), 32'(vld[i]), 32'(m_cnt[i] == bl[i]));
      chk($sformatf("count[%0d]", i), 32'(cnt[i]), m_cnt[i]);
      chk($sformatf("overflow[%0d]", i), 32'(ovf[i]), 32'(m_sum[i] > 1023));
      chk($sformatf("acc_out[%0d]", i), 32'(out[i]), m_out[i]);
    end
  endtask

  // One clock of stimulus; entered and left at posedge+1.
  task automatic step(input logic v, input logic [7:0] p, input logic r, input logic c);
    prod_valid = v;
    prod_in    = p;
    acc_ready  = r;
    clear      = c;
    #1;
    for (int i = 0; i < 3; i++)
      chk($sformatf("prod_ready[%0d]", i), 32'(rdy[i]), 32'(!c && m_cnt[i] != bl[i]));
    @(posedge clk);
    for (int i = 0; i < 3; i++) begin
      if (c) begin
        m_sum[i] = 0;
        m_cnt[i] = 0;
      end else if (m_cnt[i] == bl[i]) begin
        if (r) begin
          m_sum[i] = 0;
          m_cnt[i] = 0;
        end
      end else if (v) begin
        m_sum[i] += int'(p);
        m_cnt[i]++;
        if (m_cnt[i] == bl[i]) m_out[i] = result_of(m_sum[i]);
      end
    end
    #1;
    check_regs();
  endtask

  task automatic do_reset();
    prod_valid = 1'b0;
    prod_in    = 8'd0;
    acc_ready  = 1'b0;
    clear      = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("rst_acc_valid[%0d]", i), 32'(vld[i]), 32'd0);
      chk($sformatf("rst_count[%0d]", i), 32'(cnt[i]), 32'd0);
      chk($sformatf("rst_overflow[%0d]", i), 32'(ovf[i]), 32'd0);
      chk($sformatf("rst_acc_out[%0d]", i), 32'(out[i]), 32'd0);
      m_sum[i] = 0;
      m_cnt[i] = 0;
      m_out[i] = 0;
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++)
      chk($sformatf("rst_prod_ready[%0d]", i), 32'(rdy[i]), 32'd1);
    check_regs();
  endtask

  initial begin
    bl[0] = 4; bl[1] = 8; bl[2] = 1;
    rst_n      = 1'b0;
    prod_valid = 1'b0;
    prod_in    = 8'd0;
    acc_ready  = 1'b0;
    clear      = 1'b0;
    @(posedge clk);
    #1;
    do_reset();

    // basic block of 15x15 products, then the 8-long block overflows
    repeat (4) step(1'b1, 8'd225, 1'b0, 1'b0);
    chk("basic_acc_out", 32'(out[0]), 32'd900);
    chk("basic_acc_valid", 32'(vld[0]), 32'd1);
    repeat (4) step(1'b1, 8'd225, 1'b0, 1'b0);
`ifdef PRODUCT_ACC_SATURATE_EN
    chk("ovf8_acc_out", 32'(out[1]), 32'd1023);
`else
    chk("ovf8_acc_out", 32'(out[1]), 32'd776);
`endif
    chk("ovf8_overflow", 32'(ovf[1]), 32'd1);
    chk("basic_held", 32'(out[0]), 32'd900);
    step(1'b0, 8'd0, 1'b1, 1'b0);
    chk("basic_count_after_hs", 32'(cnt[0]), 32'd0);

    // backpressure: 7 must wait behind an unaccepted result
    step(1'b1, 8'd1, 1'b0, 1'b0);
    step(1'b1, 8'd2, 1'b0, 1'b0);
    step(1'b1, 8'd3, 1'b0, 1'b0);
    step(1'b1, 8'd4, 1'b0, 1'b0);
    repeat (5) step(1'b1, 8'd7, 1'b0, 1'b0);
    chk("bp_acc_out", 32'(out[0]), 32'd10);
    step(1'b1, 8'd7, 1'b1, 1'b0);
    step(1'b1, 8'd7, 1'b0, 1'b0);
    chk("bp_first_of_next", 32'(cnt[0]), 32'd1);

    // clear mid-block and in DONE
    step(1'b0, 8'd0, 1'b0, 1'b1);
    step(1'b1, 8'd50, 1'b0, 1'b0);
    step(1'b1, 8'd60, 1'b0, 1'b0);
    step(1'b1, 8'd70, 1'b0, 1'b1);
    chk("clr_count", 32'(cnt[0]), 32'd0);
    repeat (4) step(1'b1, 8'd1, 1'b0, 1'b0);
    chk("clr_acc_out", 32'(out[0]), 32'd4);
    step(1'b0, 8'd0, 1'b0, 1'b1);
    chk("clr_done_drop", 32'(vld[0]), 32'd0);

    // single-product blocks
    step(1'b1, 8'h00, 1'b0, 1'b0);
    chk("bl1_zero_valid", 32'(vld[2]), 32'd1);
    step(1'b0, 8'd0, 1'b1, 1'b0);
    step(1'b1, 8'hFF, 1'b0, 1'b0);
    chk("bl1_ff_out", 32'(out[2]), 32'd255);

    // asynchronous reset while results are pending
    repeat (3) step(1'b1, 8'd200, 1'b0, 1'b0);
    do_reset();

    // randomized traffic
    for (int n = 0; n < 600; n++) begin
      step(($urandom_range(0, 9) < 7), 8'($urandom_range(0, 255)),
           ($urandom_range(0, 1) == 1), ($urandom_range(0, 39) == 0));
      if (n == 300) do_reset();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
